// File: rtl/hba_reset_seq.sv
// hba_reset_seq: power-on / recovery reset sequencer.
// Qualifies PLL lock, holds all reset domains for a programmable time, then
// releases NUM_STAGES active-high resets in ascending order with a fixed gap.
// Lock loss or a software request re-asserts every stage together.
module hba_reset_seq #(
   parameter int NUM_STAGES  = 3,
   parameter int LOCK_FILTER = 8,
   parameter int HOLD_CYCLES = 10,
   parameter int STAGE_GAP   = 4,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pll_locked,
   input  logic                  sw_reset_req,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  ready,
   output logic [1:0]            seq_state
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t               state;
   logic                 lock_meta;
   logic                 lock_s;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [IDX_W-1:0]     idx;

   assign cnt_inc   = cnt + 1'b1;
   assign seq_state = state;

   // Two-flop synchronizer bringing the raw PLL lock into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: every register here, synchronizer included, has an async reset so
      // the block comes out of reset_n in a fully known state; there are no
      // memories, so nothing is left unreset.
      if (!reset_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep the two stages a true shift
         // register; blocking ones would collapse them into a single flop.
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   // Sequencer FSM with registered rst_out / ready / state.
   // The lock filter counts the edges on which lock_s is loaded with 1, so
   // qualification finishes on the same edge lock_s completes its run of highs.
   // Aborts in HOLD/RELEASE/RUN look at lock_s itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= WAIT_LOCK;
         cnt     <= '0;
         idx     <= '0;
         rst_out <= '1;
         ready   <= 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               if (!lock_meta) begin
                  cnt <= '0;
               end else if (cnt_inc == CNT_WIDTH'(LOCK_FILTER)) begin
                  state <= HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end

            default: begin
               if (!lock_s) begin
                  // Lock lost: everything back to the start, lock must requalify.
                  state   <= WAIT_LOCK;
                  cnt     <= '0;
                  idx     <= '0;
                  rst_out <= '1;
                  ready   <= 1'b0;
               end else if (sw_reset_req) begin
                  // Software request: lock is still good, so restart from HOLD.
                  state   <= HOLD;
                  cnt     <= '0;
                  idx     <= '0;
                  rst_out <= '1;
                  ready   <= 1'b0;
               end else begin
                  case (state)
                     HOLD: begin
                        if (cnt_inc == CNT_WIDTH'(HOLD_CYCLES)) begin
                           rst_out[0] <= 1'b0;
                           cnt        <= '0;
                           if (NUM_STAGES == 1) begin
                              state <= RUN;
                              ready <= 1'b1;
                           end else begin
                              state <= RELEASE;
                              idx   <= IDX_W'(1);
                           end
                        end else begin
                           cnt <= cnt_inc;
                        end
                     end

                     RELEASE: begin
                        if (cnt_inc == CNT_WIDTH'(STAGE_GAP)) begin
                           rst_out[idx] <= 1'b0;
                           cnt          <= '0;
                           if (idx == IDX_W'(NUM_STAGES - 1)) begin
                              state <= RUN;
                              ready <= 1'b1;
                           end else begin
                              idx <= idx + 1'b1;
                           end
                        end else begin
                           cnt <= cnt_inc;
                        end
                     end

                     RUN: begin
                        rst_out <= '0;
                        ready   <= 1'b1;
                     end

                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule
